extbus_initiator: RTL and testbench

- Bus-cycle generator that drives VERA's 8-bit external host bus (rd_n/wr_n strobes, 5-bit address, 8-bit data, irq_n) from a simple request/response interface.
- It sits on the initiator side of the bus. Uses:
  - simulation harnesses;
  - an on-board self-test/bring-up controller that exercises the VERA register file without a real 6502 host.
- Generates programmable setup/strobe/hold timing.
- Captures read data and synchronizes the IRQ line back to the local clock.

---
 rtl/extbus_initiator_pkg.sv | 24 ++
 rtl/extbus_initiator_sync2.sv | 24 ++
 rtl/extbus_initiator.sv | 108 ++++++++++
 tb/tb_extbus_initiator.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/extbus_initiator_pkg.sv
// Shared definitions for the external host-bus initiator: bus widths, default
// phase timing and FSM state encoding.
package extbus_initiator_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  localparam int DEF_SETUP_CYCLES  = 2;
  localparam int DEF_STROBE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Phase counter counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [3:0] phase_load(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/extbus_initiator_sync2.sv
// Two-flop synchronizer for an asynchronous level; 2-cycle latency, no backpressure.
// Both flops reset to RESET_VAL so a deasserted line reads as idle out of reset.
module extbus_initiator_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      dout <= RESET_VAL;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/extbus_initiator.sv
// Drives setup/strobe/hold bus cycles on the external host bus from a valid/ready request;
// period 1+SETUP+STROBE+HOLD cycles, req_ready only in IDLE, rsp_valid in the first HOLD cycle.
module extbus_initiator
  import extbus_initiator_pkg::*;
#(
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic              clk25,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              irq,
  output logic              extbus_rd_n,
  output logic              extbus_wr_n,
  output logic [ADDR_W-1:0] extbus_a,
  output logic [DATA_W-1:0] extbus_d_o,
  output logic              extbus_d_oe,
  input  logic [DATA_W-1:0] extbus_d_i,
  input  logic              extbus_irq_n
);

  state_t     state;
  logic [3:0] cnt;
  logic       is_write;
  logic       irq_n_sync;

  extbus_initiator_sync2 #(.RESET_VAL(1'b1)) u_irq_sync (
    .clk   (clk25),
    .reset (reset),
    .din   (extbus_irq_n),
    .dout  (irq_n_sync)
  );

  assign irq = ~irq_n_sync;

  always_ff @(posedge clk25) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      is_write    <= 1'b0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      extbus_rd_n <= 1'b1;
      extbus_wr_n <= 1'b1;
      extbus_a    <= '0;
      extbus_d_o  <= '0;
      extbus_d_oe <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_ready && req_valid) begin
            req_ready   <= 1'b0;
            is_write    <= req_write;
            extbus_a    <= req_addr;
            extbus_d_oe <= req_write;
            if (req_write) extbus_d_o <= req_wdata;
            cnt         <= phase_load(SETUP_CYCLES);
            state       <= ST_SETUP;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (cnt == 4'd0) begin
            cnt   <= phase_load(STROBE_CYCLES);
            state <= ST_STROBE;
            if (is_write) extbus_wr_n <= 1'b0;
            else          extbus_rd_n <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_STROBE: begin
          if (cnt == 4'd0) begin
            // Sample read data on the last edge the strobe is still low.
            if (!is_write) rsp_rdata <= extbus_d_i;
            extbus_rd_n <= 1'b1;
            extbus_wr_n <= 1'b1;
            rsp_valid   <= 1'b1;
            cnt         <= phase_load(HOLD_CYCLES);
            state       <= ST_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt == 4'd0) begin
            extbus_d_oe <= 1'b0;
            req_ready   <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_extbus_initiator.sv
// Directed bench for extbus_initiator: default-timing instance plus a 1/1/1 timing instance,
// with a response scoreboard filled at accept time and drained on rsp_valid.
module tb_extbus_initiator;

  localparam int S = 2;
  localparam int T = 4;
  localparam int H = 2;

  typedef struct packed {
    logic       w;
    logic [7:0] rd;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_valid1;
  logic       req_write;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] tgt_data;
  logic       irq_n;

  logic       req_ready, rsp_valid, irq, rd_n, wr_n, d_oe;
  logic [7:0] rsp_rdata, d_o, d_i;
  logic [4:0] a;

  logic       req_ready1, rsp_valid1, irq1, rd_n1, wr_n1, d_oe1;
  logic [7:0] rsp_rdata1, d_o1, d_i1;
  logic [4:0] a1;

  int checks = 0;
  int failures = 0;
  int rsp_count = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Target model: drives read data only while the strobe is low.
  assign d_i  = !rd_n  ? tgt_data : 8'hEE;
  assign d_i1 = !rd_n1 ? tgt_data : 8'hEE;

  extbus_initiator dut (
    .clk25(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .irq(irq),
    .extbus_rd_n(rd_n), .extbus_wr_n(wr_n), .extbus_a(a), .extbus_d_o(d_o),
    .extbus_d_oe(d_oe), .extbus_d_i(d_i), .extbus_irq_n(irq_n)
  );

  extbus_initiator #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) dut1 (
    .clk25(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .irq(irq1),
    .extbus_rd_n(rd_n1), .extbus_wr_n(wr_n1), .extbus_a(a1), .extbus_d_o(d_o1),
    .extbus_d_oe(d_oe1), .extbus_d_i(d_i1), .extbus_irq_n(irq_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard drain plus per-cycle bus legality.
  always @(posedge clk) begin
    #1;
    chk("strobe_excl", 32'(!rd_n && !wr_n), 32'd0);
    chk("oe_during_read", 32'(!rd_n && d_oe), 32'd0);
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_spurious", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        rsp_count++;
        if (!e.w) chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rd));
      end
    end
  end

  // Runs one transaction on dut starting in its accept cycle; fields for the
  // following request are applied right after accept.
  task automatic txn(input logic nv, input logic nw, input logic [4:0] na, input logic [7:0] nd);
    logic       w, s;
    logic [4:0] ta;
    logic [7:0] td;
    exp_t       e;
    w  = req_write;
    ta = req_addr;
    td = req_wdata;
    e.w  = w;
    e.rd = tgt_data;
    chk("accept_ready", 32'(req_ready), 32'd1);
    exp_q.push_back(e);
    step();
    req_valid = nv;
    req_write = nw;
    req_addr  = na;
    req_wdata = nd;
    for (int c = 1; c < S + T + H + 1; c++) begin
      s = (c >= S + 1) && (c <= S + T);
      chk("bus_ctl", 32'({req_ready, rsp_valid, rd_n, wr_n, d_oe}),
          32'({1'b0, c == S + T + 1, !(s && !w), !(s && w), w}));
      chk("bus_addr", 32'(a), 32'(ta));
      if (w) chk("bus_wdata", 32'(d_o), 32'(td));
      step();
    end
    chk("ready_again", 32'({req_ready, d_oe, rd_n, wr_n}), 32'(4'b1011));
  endtask

  initial begin
    int base, lows;
    reset = 1'b1; req_valid = 1'b0; req_valid1 = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; tgt_data = '0; irq_n = 1'b1;
    repeat (3) step();

    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_strobes", 32'({rd_n, wr_n}), 32'(2'b11));
    chk("rst_addr", 32'(a), 32'd0);
    chk("rst_d_o", 32'(d_o), 32'd0);
    chk("rst_d_oe", 32'(d_oe), 32'd0);
    reset = 1'b0;
    step();
    chk("ready_after_reset", 32'({req_ready, req_ready1}), 32'(2'b11));

    // Write with default timing.
    base = rsp_count;
    req_write = 1'b1; req_addr = 5'h03; req_wdata = 8'hA5; req_valid = 1'b1;
    txn(1'b0, 1'b0, 5'h00, 8'h00);
    chk("write_rsp_count", 32'(rsp_count), 32'(base + 1));

    // Read with default timing.
    base = rsp_count;
    tgt_data = 8'h5C;
    req_write = 1'b0; req_addr = 5'h1F; req_valid = 1'b1;
    txn(1'b0, 1'b0, 5'h00, 8'h00);
    chk("read_rsp_count", 32'(rsp_count), 32'(base + 1));
    chk("read_rdata_held", 32'(rsp_rdata), 32'h5C);

    // Back-to-back: write, then read queued with req_valid held high.
    base = rsp_count;
    tgt_data = 8'hC3;
    req_write = 1'b1; req_addr = 5'h0A; req_wdata = 8'h3C; req_valid = 1'b1;
    txn(1'b1, 1'b0, 5'h15, 8'hFF);
    txn(1'b0, 1'b0, 5'h00, 8'h00);
    chk("b2b_rsp_count", 32'(rsp_count), 32'(base + 2));

    // Minimum timing instance: one cycle per phase.
    tgt_data = 8'h3A;
    req_write = 1'b0; req_addr = 5'h07; req_valid1 = 1'b1;
    chk("t1_accept_ready", 32'(req_ready1), 32'd1);
    step();
    req_valid1 = 1'b0;
    lows = 0;
    for (int c = 1; c <= 3; c++) begin
      if (!rd_n1) lows++;
      chk("t1_ctl", 32'({req_ready1, rsp_valid1, wr_n1, d_oe1}), 32'({1'b0, c == 3, 1'b1, 1'b0}));
      if (c == 3) chk("t1_rdata", 32'(rsp_rdata1), 32'h3A);
      step();
    end
    chk("t1_ready_again", 32'(req_ready1), 32'd1);
    chk("t1_strobe_len", 32'(lows), 32'd1);

    // Reset in the middle of a write strobe.
    base = rsp_count;
    req_write = 1'b1; req_addr = 5'h12; req_wdata = 8'h77; req_valid = 1'b1;
    chk("abort_accept_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    repeat (3) step();
    chk("abort_mid_strobe", 32'(wr_n), 32'd0);
    reset = 1'b1;
    step();
    chk("abort_reset_state", 32'({wr_n, d_oe, req_ready, rsp_valid}), 32'(4'b1000));
    reset = 1'b0;
    step();
    chk("abort_ready_after", 32'(req_ready), 32'd1);
    repeat (10) step();
    chk("abort_no_rsp", 32'(rsp_count), 32'(base));

    // IRQ toggled asynchronously while a read is mid-strobe.
    base = rsp_count;
    tgt_data = 8'h99;
    req_write = 1'b0; req_addr = 5'h05; req_valid = 1'b1;
    fork
      txn(1'b0, 1'b0, 5'h00, 8'h00);
      begin
        repeat (4) @(posedge clk);
        #3 irq_n = 1'b0;
        @(posedge clk); #1;
        chk("irq_assert_1cyc", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("irq_assert_2cyc", 32'({irq, irq1}), 32'(2'b11));
        #2 irq_n = 1'b1;
        @(posedge clk); #1;
        chk("irq_release_1cyc", 32'(irq), 32'd1);
        @(posedge clk); #1;
        chk("irq_release_2cyc", 32'(irq), 32'd0);
      end
    join
    chk("irq_rsp_count", 32'(rsp_count), 32'(base + 1));

    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
